// File: rtl/down_timer.sv
// Loadable down-counter with pause, abort and optional auto-reload at terminal count.
// Outputs come straight from flops or from a decode of the registered state.
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (load) begin
                    count_d  = load_val;
                    reload_d = load_val;
                    state_d  = (start && load_val != ZERO) ? RUN : IDLE;
                end else if (start) begin
                    if (state_q == DONE) begin
                        count_d = reload_q;
                        state_d = (reload_q != ZERO) ? RUN : IDLE;
                    end else begin
                        state_d = (count_q != ZERO) ? RUN : IDLE;
                    end
                end
            end

            RUN: begin
                // Priority: stop, then pause, then terminal count / decrement.
                if (stop) begin
                    state_d = IDLE;
                end else if (pause) begin
                    state_d = PAUSE;
                end else if (count_q == ONE) begin
                    tc_d = 1'b1;
                    if (auto_reload) begin
                        count_d = reload_q;
                    end else begin
                        count_d = ZERO;
                        state_d = DONE;
                    end
                end else if (count_q != ZERO) begin
                    count_d = count_q - ONE;
                end
            end

            PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == RUN) || (state_q == PAUSE);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: each step pushes its expected post-edge outputs to a
// scoreboard queue, which is popped and compared one time unit after the clock edge.
module tb_down_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic       auto_reload = 1'b0;
    logic [3:0] count;
    logic       busy;
    logic       tc;
    logic       done;

    typedef struct packed {
        logic [3:0] count;
        logic       busy;
        logic       tc;
        logic       done;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   step_n = 0;

    down_timer #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .auto_reload(auto_reload),
        .count      (count),
        .busy       (busy),
        .tc         (tc),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d observed=%0h expected=%0h", tag, step_n, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, record the expected outputs after the edge, then compare.
    task automatic step(input logic r, input logic l, input logic s, input logic p,
                        input logic st, input logic ar, input logic [3:0] lv,
                        input logic [3:0] ec, input logic eb, input logic et, input logic ed);
        exp_t e;
        reset       = r;
        load        = l;
        start       = s;
        pause       = p;
        stop        = st;
        auto_reload = ar;
        load_val    = lv;
        sb_q.push_back('{count: ec, busy: eb, tc: et, done: ed});
        @(posedge clk);
        #1;
        step_n++;
        e = sb_q.pop_front();
        check("count", {28'd0, count}, {28'd0, e.count});
        check("busy",  {31'd0, busy},  {31'd0, e.busy});
        check("tc",    {31'd0, tc},    {31'd0, e.tc});
        check("done",  {31'd0, done},  {31'd0, e.done});
    endtask

    initial begin
        //   r  l  s  p  st ar lv     cnt busy tc done
        // Reset, then reset dominating every other input
        step(1, 0, 0, 0, 0, 0, 4'd0,  4'd0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 0, 4'd9,  4'd0, 0, 0, 0);

        // Load 3 + start, single-shot countdown into DONE
        step(0, 1, 1, 0, 0, 0, 4'd3,  4'd3, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd2, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd0, 0, 0, 1);

        // From DONE: load 6 + start, run to DONE
        step(0, 1, 1, 0, 0, 0, 4'd6,  4'd6, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd5, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd4, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd3, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd2, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd0, 0, 1, 1);

        // Start held in DONE restarts from the reload value; start ignored in RUN; stop holds count
        step(0, 0, 1, 0, 0, 0, 4'd0,  4'd6, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 4'd0,  4'd5, 1, 0, 0);
        step(0, 0, 1, 0, 1, 0, 4'd0,  4'd5, 0, 0, 0);

        // Start from IDLE with count 5, then reset mid-RUN
        step(0, 0, 1, 0, 0, 0, 4'd0,  4'd5, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 4'd0,  4'd0, 0, 0, 0);

        // Start with count 0 in IDLE is ignored
        step(0, 0, 1, 0, 0, 0, 4'd0,  4'd0, 0, 0, 0);

        // Auto-reload with reload value 2
        step(0, 1, 1, 0, 0, 1, 4'd2,  4'd2, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 4'd0,  4'd1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 4'd0,  4'd2, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, 4'd0,  4'd1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 4'd0,  4'd2, 1, 1, 0);
        // load ignored in RUN
        step(0, 1, 1, 0, 0, 1, 4'd9,  4'd1, 1, 0, 0);
        // stop + pause at count 1: stop wins, no terminal count
        step(0, 0, 0, 1, 1, 1, 4'd0,  4'd1, 0, 0, 0);
        // stop ignored in IDLE
        step(0, 0, 0, 0, 1, 0, 4'd0,  4'd1, 0, 0, 0);

        // Pause holds count; resume decrements on the following edge
        step(0, 1, 1, 0, 0, 0, 4'd6,  4'd6, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd5, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd4, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  4'd4, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0, 4'd9,  4'd4, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0, 4'd0,  4'd4, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd4, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd3, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd2, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd1, 1, 0, 0);
        // pause at count 1 beats terminal count
        step(0, 0, 0, 1, 0, 0, 4'd0,  4'd1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd0, 0, 1, 1);

        // Reload value 1 with auto-reload: tc every cycle
        step(0, 1, 1, 0, 0, 1, 4'd1,  4'd1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 4'd0,  4'd1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, 4'd0,  4'd1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 4'd0,  4'd0, 0, 1, 1);

        // Load without start from DONE goes to IDLE; load 0 + start stays IDLE
        step(0, 1, 0, 0, 0, 0, 4'd7,  4'd7, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 4'd0,  4'd0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 4'd0,  4'd0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
